// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter: NUM_SRC valid/ready sources share one registered valid/ready
// destination, with grants held for bursts of up to MAX_BURST beats under contention.
module rr_handshake_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        valid_s,
  input  logic [NUM_SRC*DATA_W-1:0] data_s,
  output logic [NUM_SRC-1:0]        ready_s,
  input  logic                      ready_d,
  output logic                      valid_d,
  output logic [DATA_W-1:0]         data_d,
  output logic [ID_W-1:0]           src_id_d
);

  localparam int unsigned NSRC = NUM_SRC;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [ID_W-1:0]  g;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] burst_cnt;
  logic             hold;

  logic [NUM_SRC-1:0] g_onehot;
  logic [NUM_SRC-1:0] others;
  logic               xfer;
  logic               release_g;
  logic [ID_W-1:0]    next_start;
  logic [ID_W:0]      idle_pick;
  logic [ID_W:0]      rel_pick;
  logic [DATA_W-1:0]  g_data;

  // Returns {found, index} of the first set request searching circularly from start.
  function automatic logic [ID_W:0] pick(input logic [NUM_SRC-1:0] req,
                                         input logic [ID_W-1:0] start);
    logic [ID_W:0]   r;
    logic [ID_W-1:0] idx;
    r = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      idx = ID_W'((32'(start) + k) % NSRC);
      if (!r[ID_W] && req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    g_onehot   = {{(NUM_SRC-1){1'b0}}, 1'b1} << g;
    others     = valid_s & ~g_onehot;
    // hold gates the single dead cycle that follows a burst-limit handoff
    ready_s    = (state == GRANT && !hold && (!valid_d || ready_d)) ? g_onehot : '0;
    xfer       = (state == GRANT) && valid_s[g] && ready_s[g];
    release_g  = (state == GRANT) &&
                 (!valid_s[g] || (xfer && burst_cnt == LAST && |others));
    next_start = (g == ID_W'(NUM_SRC - 1)) ? '0 : g + 1'b1;
    idle_pick  = pick(valid_s, ptr);
    rel_pick   = pick(others, next_start);
    g_data     = data_s[g*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      g         <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      hold      <= 1'b0;
      valid_d   <= 1'b0;
      data_d    <= '0;
      src_id_d  <= '0;
    end else begin
      if (xfer) begin
        valid_d  <= 1'b1;
        data_d   <= g_data;
        src_id_d <= g;
      end else if (ready_d) begin
        valid_d <= 1'b0;
      end

      hold <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_pick[ID_W]) begin
            g         <= idle_pick[ID_W-1:0];
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) burst_cnt <= (burst_cnt == LAST) ? '0 : burst_cnt + 1'b1;
          if (release_g) begin
            ptr <= next_start;
            if (rel_pick[ID_W]) begin
              g         <= rel_pick[ID_W-1:0];
              burst_cnt <= '0;
              hold      <= xfer;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Directed bench for rr_handshake_arbiter: sources are modelled as simple counters
// that advance on each accepted beat; expected outputs are hand-computed per cycle.
module tb_rr_handshake_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid_s;
  logic [31:0] data_s;
  logic [3:0]  ready_s;
  logic        ready_d;
  logic        valid_d;
  logic [7:0]  data_d;
  logic [1:0]  src_id_d;

  logic [7:0] src_data [4];
  int         src_left [4];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  rr_handshake_arbiter #(.NUM_SRC(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_s(valid_s), .data_s(data_s), .ready_s(ready_s),
    .ready_d(ready_d), .valid_d(valid_d), .data_d(data_d), .src_id_d(src_id_d)
  );

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      valid_s[i]       = (src_left[i] > 0);
      data_s[i*8 +: 8] = src_data[i];
    end
  endtask

  // One clock: record which sources handshake, cross the edge, then advance them.
  task automatic tick();
    logic [3:0] acc;
    acc = valid_s & ready_s;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i]) begin
        src_data[i] = src_data[i] + 8'd1;
        src_left[i] = src_left[i] - 1;
      end
    apply();
    #1;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      src_left[i] = 0;
      src_data[i] = '0;
    end
    apply();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_sources();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    ready_d = 1'b1;
    clear_sources();
    tick();
    tick();
    vectors++; if (valid_d !== 1'b0) begin miscompares++; $display("FAIL reset valid_d: got %b expected 0", valid_d); end
    vectors++; if (data_d !== 8'h00) begin miscompares++; $display("FAIL reset data_d: got %h expected 00", data_d); end
    vectors++; if (src_id_d !== 2'd0) begin miscompares++; $display("FAIL reset src_id_d: got %0d expected 0", src_id_d); end
    vectors++; if (ready_s !== 4'b0000) begin miscompares++; $display("FAIL reset ready_s: got %b expected 0000", ready_s); end
    rst_n = 1'b1;
    tick();
    vectors++; if (ready_s !== 4'b0000) begin miscompares++; $display("FAIL idle ready_s: got %b expected 0000", ready_s); end
    vectors++; if (valid_d !== 1'b0) begin miscompares++; $display("FAIL idle valid_d: got %b expected 0", valid_d); end
  endtask

  task automatic test_single_stream();
    logic [7:0] exp_d;
    src_data[2] = 8'h10;
    src_left[2] = 8;
    apply();
    #1;
    vectors++; if (ready_s !== 4'b0000) begin miscompares++; $display("FAIL stream arb ready_s: got %b expected 0000", ready_s); end
    tick();
    vectors++; if (ready_s !== 4'b0100) begin miscompares++; $display("FAIL stream grant ready_s: got %b expected 0100", ready_s); end
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_d = 8'h10 + 8'(k);
      vectors++; if (valid_d !== 1'b1) begin miscompares++; $display("FAIL stream valid beat %0d: got %b expected 1", k, valid_d); end
      vectors++; if (data_d !== exp_d) begin miscompares++; $display("FAIL stream data beat %0d: got %h expected %h", k, data_d, exp_d); end
      vectors++; if (src_id_d !== 2'd2) begin miscompares++; $display("FAIL stream id beat %0d: got %0d expected 2", k, src_id_d); end
    end
    tick();
    vectors++; if (valid_d !== 1'b0) begin miscompares++; $display("FAIL stream end valid_d: got %b expected 0", valid_d); end
  endtask

  // Runs straight after test_single_stream, which leaves ptr at 3.
  task automatic test_wraparound();
    logic       ev  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed  [7] = '{8'h00, 8'hD0, 8'hD1, 8'h00, 8'hA0, 8'hA1, 8'h00};
    logic [1:0] eid [7] = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    src_data[0] = 8'hA0; src_left[0] = 2;
    src_data[3] = 8'hD0; src_left[3] = 2;
    apply();
    #1;
    for (int t = 0; t < 7; t++) begin
      tick();
      vectors++; if (valid_d !== ev[t]) begin miscompares++; $display("FAIL wrap valid t%0d: got %b expected %b", t + 1, valid_d, ev[t]); end
      if (ev[t]) begin
        vectors++; if (data_d !== ed[t]) begin miscompares++; $display("FAIL wrap data t%0d: got %h expected %h", t + 1, data_d, ed[t]); end
        vectors++; if (src_id_d !== eid[t]) begin miscompares++; $display("FAIL wrap id t%0d: got %0d expected %0d", t + 1, src_id_d, eid[t]); end
      end
    end
  endtask

  task automatic test_rotation();
    int         p;
    logic [1:0] exp_id;
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_data[i] = 8'(i * 64);
      src_left[i] = 100;
    end
    apply();
    #1;
    for (int t = 1; t <= 25; t++) begin
      tick();
      if (t == 1) begin
        vectors++; if (valid_d !== 1'b0) begin miscompares++; $display("FAIL rot arb valid: got %b expected 0", valid_d); end
      end else begin
        p      = (t - 2) % 5;
        exp_id = 2'(((t - 2) / 5) % 4);
        exp_d  = 8'(exp_id * 64 + ((t - 2) / 20) * 4 + p);
        if (p == 4) begin
          vectors++; if (valid_d !== 1'b0) begin miscompares++; $display("FAIL rot gap t%0d: got valid %b expected 0", t, valid_d); end
        end else begin
          vectors++; if (valid_d !== 1'b1) begin miscompares++; $display("FAIL rot valid t%0d: got %b expected 1", t, valid_d); end
          vectors++; if (src_id_d !== exp_id) begin miscompares++; $display("FAIL rot id t%0d: got %0d expected %0d", t, src_id_d, exp_id); end
          vectors++; if (data_d !== exp_d) begin miscompares++; $display("FAIL rot data t%0d: got %h expected %h", t, data_d, exp_d); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic       ev  [15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed  [15] = '{8'h00, 8'h30, 8'h31, 8'h31, 8'h31, 8'h31, 8'h32, 8'h33,
                             8'h00, 8'h50, 8'h51, 8'h00, 8'h34, 8'h35, 8'h00};
    logic [1:0] eid [15] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                             2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
    do_reset();
    src_data[1] = 8'h30; src_left[1] = 6;
    src_data[2] = 8'h50; src_left[2] = 2;
    apply();
    #1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      vectors++; if (valid_d !== ev[t-1]) begin miscompares++; $display("FAIL bp valid t%0d: got %b expected %b", t, valid_d, ev[t-1]); end
      if (ev[t-1]) begin
        vectors++; if (data_d !== ed[t-1]) begin miscompares++; $display("FAIL bp data t%0d: got %h expected %h", t, data_d, ed[t-1]); end
        vectors++; if (src_id_d !== eid[t-1]) begin miscompares++; $display("FAIL bp id t%0d: got %0d expected %0d", t, src_id_d, eid[t-1]); end
      end
      if (t == 3) ready_d = 1'b0;
      if (t == 6) ready_d = 1'b1;
      #1;
      if (t >= 3 && t <= 5) begin
        vectors++; if (ready_s !== 4'b0000) begin miscompares++; $display("FAIL bp stall ready_s t%0d: got %b expected 0000", t, ready_s); end
      end
      if (t == 6) begin
        vectors++; if (ready_s !== 4'b0010) begin miscompares++; $display("FAIL bp resume ready_s: got %b expected 0010", ready_s); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    src_data[1] = 8'h11; src_left[1] = 1;
    apply();
    #1;
    tick();
    tick();
    vectors++; if (data_d !== 8'h11 || valid_d !== 1'b1) begin miscompares++; $display("FAIL rmb pre beat: got %b/%h expected 1/11", valid_d, data_d); end
    tick();
    src_data[2] = 8'h20; src_left[2] = 10;
    apply();
    #1;
    tick();
    tick();
    tick();
    vectors++; if (data_d !== 8'h21 || src_id_d !== 2'd2) begin miscompares++; $display("FAIL rmb burst: got %h/%0d expected 21/2", data_d, src_id_d); end
    rst_n = 1'b0;
    src_data[0] = 8'h05; src_left[0] = 3;
    apply();
    #1;
    tick();
    vectors++; if (valid_d !== 1'b0) begin miscompares++; $display("FAIL rmb valid_d: got %b expected 0", valid_d); end
    vectors++; if (data_d !== 8'h00) begin miscompares++; $display("FAIL rmb data_d: got %h expected 00", data_d); end
    vectors++; if (src_id_d !== 2'd0) begin miscompares++; $display("FAIL rmb src_id_d: got %0d expected 0", src_id_d); end
    vectors++; if (ready_s !== 4'b0000) begin miscompares++; $display("FAIL rmb ready_s: got %b expected 0000", ready_s); end
    rst_n = 1'b1;
    tick();
    vectors++; if (ready_s !== 4'b0001) begin miscompares++; $display("FAIL rmb restart grant: got %b expected 0001", ready_s); end
    tick();
    vectors++; if (valid_d !== 1'b1 || data_d !== 8'h05 || src_id_d !== 2'd0) begin
      miscompares++; $display("FAIL rmb restart beat: got %b/%h/%0d expected 1/05/0", valid_d, data_d, src_id_d);
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_wraparound();
    test_rotation();
    test_backpressure();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
